// File: rtl/pci_reg_arbiter.sv
// pci_reg_arbiter
//
// Round-robin arbiter and sequencer. It shares one register-file access port
// among NREQ request agents. One requester is granted at a time. Its
// address, data and write enable are latched onto reg_sel/reg_wr/reg_addr/
// reg_wdata. The block then waits for reg_ready, or gives up after TIMEOUT
// cycles, and returns a one-cycle pci_ack pulse with rdata/ack_err to the
// winner.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   req        per-requester request level, held until the matching pci_ack
//   req_we     per-requester write enable, sampled at grant
//   req_addr   packed addresses, requester i at [i*AW +: AW]
//   req_wdata  packed write data, requester i at [i*DW +: DW]
//   pci_ack    one-hot completion pulse, one cycle wide (registered)
//   ack_err    1 = access aborted by timeout; valid with pci_ack (registered)
//   rdata      read data, valid with pci_ack (registered)
//   reg_sel    register access strobe, held for the whole access
//   reg_wr     write qualifier, only ever 1 while reg_sel = 1
//   reg_addr   register address, stable while reg_sel = 1
//   reg_wdata  register write data, stable while reg_sel = 1
//   reg_rdata  register read data, sampled when reg_ready = 1
//   reg_ready  register completion, only looked at while reg_sel = 1
//
// Handshakes: a requester raises req[i] and holds it, with stable we/addr/
// wdata, until it sees pci_ack[i] high for one cycle. Towards the register
// file, reg_sel rises with address/data already valid. It stays high with
// everything frozen until the first cycle in which reg_ready = 1, or until the
// timeout expires. reg_sel drops on the next edge.
module pci_reg_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      pci_ack,
    output logic                 ack_err,
    output logic [DW-1:0]        rdata,
    output logic                 reg_sel,
    output logic                 reg_wr,
    output logic [AW-1:0]        reg_addr,
    output logic [DW-1:0]        reg_wdata,
    input  logic [DW-1:0]        reg_rdata,
    input  logic                 reg_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    // The access is abandoned on the edge that ends its TIMEOUT-th cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   winner, winner_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   pick;

    logic [NREQ-1:0] pci_ack_n;
    logic            ack_err_n;
    logic [DW-1:0]   rdata_n;
    logic            reg_sel_n;
    logic            reg_wr_n;
    logic [AW-1:0]   reg_addr_n;
    logic [DW-1:0]   reg_wdata_n;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    // First set request at or above the pointer, wrapping from NREQ-1 to 0.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [IW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(p) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && r[idx]) begin
                sel   = IW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(req, ptr);

    always_comb begin
        state_n     = state;
        winner_n    = winner;
        ptr_n       = ptr;
        cnt_n       = cnt;
        pci_ack_n   = '0;
        ack_err_n   = 1'b0;
        rdata_n     = rdata;
        reg_sel_n   = reg_sel;
        reg_wr_n    = reg_wr;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;

        case (state)
            IDLE: begin
                if (|req) begin
                    winner_n    = pick;
                    reg_wr_n    = req_we[pick];
                    reg_addr_n  = addr_arr[pick];
                    reg_wdata_n = wdata_arr[pick];
                    reg_sel_n   = 1'b1;
                    cnt_n       = '0;
                    state_n     = ACCESS;
                end
            end

            ACCESS: begin
                // reg_ready is checked first so that it wins over a
                // timeout expiring in the same cycle.
                if (reg_ready) begin
                    rdata_n           = reg_rdata;
                    reg_sel_n         = 1'b0;
                    reg_wr_n          = 1'b0;
                    pci_ack_n[winner] = 1'b1;
                    state_n           = ACK;
                end else if (cnt == CNT_LAST) begin
                    rdata_n           = '0;
                    reg_sel_n         = 1'b0;
                    reg_wr_n          = 1'b0;
                    pci_ack_n[winner] = 1'b1;
                    ack_err_n         = 1'b1;
                    state_n           = ACK;
                end
                if (!reg_ready && cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ACK: begin
                // pci_ack is high during this state; it clears on the way out.
                ptr_n   = (winner == IDX_LAST) ? '0 : winner + 1'b1;
                state_n = IDLE;
            end

            default: begin
                state_n   = IDLE;
                reg_sel_n = 1'b0;
                reg_wr_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            winner    <= '0;
            ptr       <= '0;
            cnt       <= '0;
            pci_ack   <= '0;
            ack_err   <= 1'b0;
            rdata     <= '0;
            reg_sel   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state     <= state_n;
            winner    <= winner_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            pci_ack   <= pci_ack_n;
            ack_err   <= ack_err_n;
            rdata     <= rdata_n;
            reg_sel   <= reg_sel_n;
            reg_wr    <= reg_wr_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
        end
    end

endmodule

// File: doc/pci_reg_arbiter.md
Name: pci_reg_arbiter

Overview:
Round-robin arbiter and sequencer that shares one register-file access port among NREQ requesters. It grants one requester at a time and drives the shared reg_sel/reg_wr strobes with that requester's address and data. It waits for the register file to complete the access, then returns a one-cycle pci_ack pulse, with read data, to the granted requester. It sits between the PCI-side request agents and the register block that consumes reg_sel/reg_wr.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 8, register address width
DW, 32, register data width
TIMEOUT, 15, maximum cycles to wait for reg_ready before aborting an access (1..255)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-low
req  input  NREQ  per-requester access request; level, held until the matching pci_ack
req_we  input  NREQ  per-requester write enable (1 = write, 0 = read); sampled at grant
req_addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
req_wdata  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
pci_ack  output  NREQ  one-hot completion pulse, one cycle wide
ack_err  output  1  valid with pci_ack; 1 = access aborted by timeout
rdata  output  DW  read data; valid with pci_ack
reg_sel  output  1  register access strobe, held for the whole access
reg_wr  output  1  write qualifier; only ever 1 while reg_sel = 1
reg_addr  output  AW  register address
reg_wdata  output  DW  register write data
reg_rdata  input  DW  register read data; sampled when reg_ready = 1
reg_ready  input  1  register file completion; only meaningful while reg_sel = 1

Behaviour:
- Reset (rst low, async): state IDLE; pci_ack = 0, ack_err = 0, rdata = 0, reg_sel = 0, reg_wr = 0, reg_addr = 0, reg_wdata = 0, priority pointer = 0, timeout counter = 0.
- Reset asserted mid-access: the access is abandoned. No pci_ack is issued. The requester must re-request after reset is released.
- State IDLE: if any req bit is set, select the winner by round-robin:
  - the first set bit at or above the pointer, scanning upward and wrapping from NREQ-1 to 0;
  - register the winner index; latch its we/addr/wdata into reg_wr/reg_addr/reg_wdata;
  - set reg_sel = 1, clear the counter, go to ACCESS.
- State IDLE with req = 0: stay in IDLE.
- State ACCESS: reg_sel, reg_wr, reg_addr and reg_wdata are held stable.
  - reg_ready = 1: capture reg_rdata into rdata (writes capture too; value don't-care), drop reg_sel/reg_wr, go to ACK with ack_err = 0.
  - Counter reaches TIMEOUT without reg_ready: drop reg_sel/reg_wr, set rdata = 0, ack_err = 1, go to ACK.
  - reg_ready and timeout in the same cycle: reg_ready wins, ack_err = 0.
- State ACK: pci_ack[winner] = 1 for exactly one cycle; pointer becomes (winner+1) mod NREQ; return to IDLE.
  - pci_ack, ack_err and rdata are registered outputs.
  - ack_err is 0 whenever pci_ack = 0.
- Latency: req seen in IDLE at edge N -> reg_sel high from N+1. reg_ready at edge M -> pci_ack high during cycle M+1. Minimum: req at cycle 0, reg_sel in cycle 1, reg_ready in cycle 1, pci_ack in cycle 2.
- Back-to-back: after ACK the block returns to IDLE, so there is one idle cycle between accesses (reg_sel low for at least 2 cycles between grants).
- Requesters must hold req through pci_ack. A req that drops during ACCESS does not cancel the access; it completes and is acked.
- A requester still holding req in the cycle after its ack is treated as a new request.
- Changes to req_addr/req_wdata/req_we after grant are ignored.
- Fairness: any continuously asserted req is granted within NREQ arbitration rounds.
- Timeout counter: width ceil(log2(TIMEOUT+1)); saturates; never wraps.

Test Plan:
- Reset: hold rst = 0 with req = 4'b1111 -> all outputs 0. Release rst with req = 4'b0010, we = 1, addr = 8'h10, wdata = 32'hDEADBEEF -> reg_sel = reg_wr = 1 with addr 8'h10 and data DEADBEEF one cycle later.
- Read latency: req[0] read of addr 8'h04; reg_ready = 1 in the first reg_sel cycle with reg_rdata = 32'h12345678 -> pci_ack = 4'b0001 two cycles after req, rdata = 32'h12345678, ack_err = 0.
- Round-robin: req = 4'b1111 held; each access acks with reg_ready after 2 cycles -> ack order 0, 1, 2, 3, 0; no requester is acked twice before the others.
- Wrap-around: pointer = 3 with req = 4'b1001 -> requester 3 granted first, then 0; then req = 4'b0110 -> requester 1 granted.
- Timeout: reg_ready never asserted, TIMEOUT = 15 -> reg_sel drops after 15 cycles, pci_ack pulses with ack_err = 1 and rdata = 0. reg_ready and timeout in the same cycle -> ack_err = 0.
- Mid-access events: req drops during ACCESS -> access still completes and is acked. rst low during ACCESS -> reg_sel = 0 immediately, no ack, pointer = 0.
